// File: rtl/rca_4bit.sv
// -----------------------------------------------------------------------------
// rca_4bit -- parameterised ripple-carry adder with a registered result stage.
//
// The adder is a chain of WIDTH single-bit full-adder cells. Carry c[i] enters
// cell i and its carry out becomes c[i+1]. The combinational sum/cout outputs
// serve datapath users. A one-cycle registered copy of the result, with a
// signed-overflow flag and a valid qualifier, serves clocked consumers.
//
// Ports:
//   clk       in   rising-edge clock for the registered outputs
//   rst_n     in   asynchronous active-low reset (clears the registered stage)
//   a, b      in   WIDTH-bit operands (unsigned; two's complement for ovf_q)
//   cin       in   carry into bit 0
//   in_valid  in   qualifies a/b/cin for capture into the registered stage
//   sum       out  combinational sum bits
//   cout      out  combinational carry out of the MSB cell
//   sum_q     out  registered sum
//   cout_q    out  registered carry out
//   ovf_q     out  registered two's-complement overflow
//   out_valid out  registered qualifier for sum_q/cout_q/ovf_q
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// rca_4bit_fa -- single-bit full-adder cell.
//   a, b : operand bits    ci : carry in
//   s    : sum bit         co : carry out (majority of a, b, ci)
// -----------------------------------------------------------------------------
module rca_4bit_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// -----------------------------------------------------------------------------
// rca_4bit_chk -- simulation-time checks of the combinational adder.
//   Observes operands and results only; drives nothing.
// -----------------------------------------------------------------------------
module rca_4bit_chk #(
  parameter int WIDTH = 4
) (
  input logic [WIDTH-1:0] a,
  input logic [WIDTH-1:0] b,
  input logic             cin,
  input logic [WIDTH-1:0] sum,
  input logic             cout
);

  logic [WIDTH:0] ref_sum_s;

  assign ref_sum_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

  // Compare the ripple chain with a behavioural sum whenever operands are known.
  always_comb begin
    if (!$isunknown({a, b, cin})) begin
      assert (!$isunknown({cout, sum}))
        else $error("rca_4bit_chk: X on sum/cout with known inputs");
      assert ({cout, sum} == ref_sum_s)
        else $error("rca_4bit_chk: ripple result disagrees with a+b+cin");
    end else begin
      // Unknown operands (e.g. before stimulus starts): nothing to check.
    end
  end

endmodule

// -----------------------------------------------------------------------------
// rca_4bit -- top level.
// -----------------------------------------------------------------------------
module rca_4bit #(
  parameter int WIDTH = 4   // operand/sum width, must be >= 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             out_valid
);

  // c_s[i] is the carry into cell i; c_s[WIDTH] is the final carry out.
  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             out_valid_r;

  assign c_s[0] = cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      rca_4bit_fa u_fa (
        .a  (a[i]),
        .b  (b[i]),
        .ci (c_s[i]),
        .s  (sum_s[i]),
        .co (c_s[i+1])
      );
    end
  endgenerate

  assign sum  = sum_s;
  assign cout = c_s[WIDTH];

  // Signed overflow: carry into the sign cell differs from carry out of it.
  // For WIDTH=1 this is c[1] ^ cin since c_s[0] is cin.
  assign ovf_s = c_s[WIDTH] ^ c_s[WIDTH-1];

  // Result register: capture on in_valid, otherwise hold data and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      sum_r       <= sum_s;
      cout_r      <= c_s[WIDTH];
      ovf_r       <= ovf_s;
      out_valid_r <= 1'b1;
    end else begin
      sum_r       <= sum_r;
      cout_r      <= cout_r;
      ovf_r       <= ovf_r;
      out_valid_r <= 1'b0;
    end
  end

  assign sum_q     = sum_r;
  assign cout_q    = cout_r;
  assign ovf_q     = ovf_r;
  assign out_valid = out_valid_r;

  rca_4bit_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum_s),
    .cout (c_s[WIDTH])
  );

endmodule

// File: tb/tb_rca_4bit.sv
// -----------------------------------------------------------------------------
// tb_rca_4bit -- directed self-checking bench for rca_4bit (WIDTH=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later
// (combinational) or 1 time unit after the rising edge (registered).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rca_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       in_valid;
  logic [3:0] sum;
  logic       cout;
  logic [3:0] sum_q;
  logic       cout_q;
  logic       ovf_q;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rca_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .sum_q     (sum_q),
    .cout_q    (cout_q),
    .ovf_q     (ovf_q),
    .out_valid (out_valid)
  );

  task automatic drive(input logic [3:0] va, input logic [3:0] vb,
                       input logic vc, input logic vv);
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = vv;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  // Reset state, then the first capture after release.
  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'b0101, 4'b0011, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, ovf_q, cout_q, sum_q} !== 7'b0) begin
      errors++;
      $display("FAIL reset_regs: got %b expected %b", {out_valid, ovf_q, cout_q, sum_q}, 7'b0);
    end
    checks++;
    if ({cout, sum} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_comb: got %b expected %b", {cout, sum}, 5'b01000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 1'b0, 1'b1);
    #1;
    checks++;
    if ({cout, sum} !== 5'b00000) begin
      errors++;
      $display("FAIL zero_comb: got %b expected %b", {cout, sum}, 5'b00000);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, ovf_q, cout_q, sum_q} !== 7'b1000000) begin
      errors++;
      $display("FAIL first_capture: got %b expected %b", {out_valid, ovf_q, cout_q, sum_q}, 7'b1000000);
    end
  endtask

  // Hand-computed vectors, each checked combinationally and after one clock.
  task automatic test_vectors();
    vec_t v[9];
    v[0] = '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1}; // 5+3 signed overflow
    v[1] = '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b0, 1'b0}; // 7 + -8 = -1
    v[2] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0}; // full ripple
    v[3] = '{4'b1001, 4'b0110, 1'b1, 4'b0000, 1'b1, 1'b0}; // carry-in ripple
    v[4] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0}; // all ones
    v[5] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0}; // zero + cin
    v[6] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1}; // -8 + -8
    v[7] = '{4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b1}; // 7 + cin overflow
    v[8] = '{4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b0}; // no carries
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      drive(v[k].a, v[k].b, v[k].cin, 1'b1);
      #1;
      checks++;
      if ({cout, sum} !== {v[k].cout, v[k].sum}) begin
        errors++;
        $display("FAIL vec%0d_comb: got %b expected %b", k, {cout, sum}, {v[k].cout, v[k].sum});
      end
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, ovf_q, cout_q, sum_q} !== {1'b1, v[k].ovf, v[k].cout, v[k].sum}) begin
        errors++;
        $display("FAIL vec%0d_reg: got %b expected %b", k, {out_valid, ovf_q, cout_q, sum_q},
                 {1'b1, v[k].ovf, v[k].cout, v[k].sum});
      end
    end
  endtask

  // Three consecutive captures, then in_valid low: valid drops, data holds.
  task automatic test_back_to_back();
    vec_t v[3];
    v[0] = '{4'b0011, 4'b0100, 1'b0, 4'b0111, 1'b0, 1'b0}; // 3+4
    v[1] = '{4'b1100, 4'b0101, 1'b1, 4'b0010, 1'b1, 1'b0}; // -4+5+1
    v[2] = '{4'b0110, 4'b0110, 1'b0, 4'b1100, 1'b0, 1'b1}; // 6+6
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(v[k].a, v[k].b, v[k].cin, 1'b1);
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, ovf_q, cout_q, sum_q} !== {1'b1, v[k].ovf, v[k].cout, v[k].sum}) begin
        errors++;
        $display("FAIL b2b%0d: got %b expected %b", k, {out_valid, ovf_q, cout_q, sum_q},
                 {1'b1, v[k].ovf, v[k].cout, v[k].sum});
      end
    end
    @(negedge clk);
    drive(4'b0001, 4'b0001, 1'b0, 1'b0);
    #1;
    checks++;
    if ({cout, sum} !== 5'b00010) begin
      errors++;
      $display("FAIL idle_comb: got %b expected %b", {cout, sum}, 5'b00010);
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, ovf_q, cout_q, sum_q} !== 7'b0101100) begin
        errors++;
        $display("FAIL hold%0d: got %b expected %b", k, {out_valid, ovf_q, cout_q, sum_q}, 7'b0101100);
      end
    end
  endtask

  // Reset asserted mid-cycle while a result is valid.
  task automatic test_async_reset();
    @(negedge clk);
    drive(4'b1001, 4'b1001, 1'b0, 1'b1);  // -7 + -7: sum 0010, cout 1, ovf 1
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, ovf_q, cout_q, sum_q} !== 7'b1110010) begin
      errors++;
      $display("FAIL pre_reset: got %b expected %b", {out_valid, ovf_q, cout_q, sum_q}, 7'b1110010);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, ovf_q, cout_q, sum_q} !== 7'b0) begin
      errors++;
      $display("FAIL async_clear: got %b expected %b", {out_valid, ovf_q, cout_q, sum_q}, 7'b0);
    end
    drive(4'b0010, 4'b0011, 1'b1, 1'b1);
    #1;
    checks++;
    if ({cout, sum} !== 5'b00110) begin
      errors++;
      $display("FAIL comb_in_reset: got %b expected %b", {cout, sum}, 5'b00110);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, ovf_q, cout_q, sum_q} !== 7'b0) begin
      errors++;
      $display("FAIL held_in_reset: got %b expected %b", {out_valid, ovf_q, cout_q, sum_q}, 7'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1111, 4'b1111, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, ovf_q, cout_q, sum_q} !== 7'b1011111) begin
      errors++;
      $display("FAIL post_reset_capture: got %b expected %b", {out_valid, ovf_q, cout_q, sum_q}, 7'b1011111);
    end
  endtask

  // All 512 operand combinations against arithmetic and the sign rule.
  task automatic test_exhaustive();
    for (int i = 0; i < 512; i++) begin
      logic [3:0] va;
      logic [3:0] vb;
      logic       vc;
      logic [4:0] e;
      logic       eovf;
      va   = i[3:0];
      vb   = i[7:4];
      vc   = i[8];
      e    = {1'b0, va} + {1'b0, vb} + {4'b0000, vc};
      eovf = (va[3] == vb[3]) && (e[3] != va[3]);
      @(negedge clk);
      drive(va, vb, vc, 1'b1);
      #1;
      checks++;
      if ({cout, sum} !== e) begin
        errors++;
        $display("FAIL sweep_comb a=%h b=%h cin=%b: got %b expected %b", va, vb, vc, {cout, sum}, e);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, ovf_q, cout_q, sum_q} !== {1'b1, eovf, e}) begin
        errors++;
        $display("FAIL sweep_reg a=%h b=%h cin=%b: got %b expected %b", va, vb, vc,
                 {out_valid, ovf_q, cout_q, sum_q}, {1'b1, eovf, e});
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_async_reset();
    test_exhaustive();
    @(negedge clk);
    in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rca_4bit.md
Name: rca_4bit

Overview:
- 4-bit ripple-carry adder: sum = a + b + cin, with carry out.
- Built as a chain of single-bit full-adder cells, where carry i feeds cell i+1.
- Combinational sum/cout outputs serve datapath use.
- A registered copy of the result, with a valid flag and a signed-overflow flag, serves clocked consumers.
- Leaf arithmetic block used wherever a small adder is needed.

Parameters:
- WIDTH, 4, operand/sum width in bits. Must be ≥1. The module name reflects the default.

Ports:
- clk  input  1  rising-edge clock for the registered outputs
- rst_n  input  1  asynchronous active-low reset
- a  input  WIDTH  operand A, unsigned (also interpreted as two's complement for ovf)
- b  input  WIDTH  operand B
- cin  input  1  carry in to bit 0
- in_valid  input  1  qualifies a/b/cin for capture into the registered stage
- sum  output  WIDTH  combinational sum bits
- cout  output  1  combinational carry out of the MSB cell
- sum_q  output  WIDTH  registered sum
- cout_q  output  1  registered carry out
- ovf_q  output  1  registered two's-complement overflow
- out_valid  output  1  registered qualifier for sum_q/cout_q/ovf_q

Behaviour:
- Full-adder cell i:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i])
  - c[0] = cin; cout = c[WIDTH]
  - Implemented as WIDTH instances of one full-adder submodule, not a behavioural "+".
- Combinational outputs sum/cout:
  - Pure function of a, b, cin.
  - Independent of clk, rst_n and in_valid.
  - Settle within one propagation delay of any input change.
  - Never X when inputs are known.
- Arithmetic:
  - {cout, sum} = a + b + cin exactly, modulo 2^(WIDTH+1).
  - Overflow wraps sum; cout carries the lost bit.
- Combinational overflow: ovf = c[WIDTH] ^ c[WIDTH-1], i.e. operands share a sign and the result sign differs.
  - For WIDTH=1, ovf = c[1] ^ cin.
- Registered stage (rising clk):
  - If in_valid=1: sum_q←sum, cout_q←cout, ovf_q←ovf, out_valid←1.
  - If in_valid=0: sum_q/cout_q/ovf_q hold their values; out_valid←0.
  - Latency is exactly 1 cycle from a sampled in_valid=1 to out_valid=1 with that result.
  - Back-to-back in_valid=1 yields one result per cycle; no stall, no backpressure.
- Reset:
  - rst_n=0 immediately (asynchronously) forces sum_q=0, cout_q=0, ovf_q=0, out_valid=0.
  - Combinational sum/cout are unaffected by reset.
  - Reset asserted mid-stream discards the in-flight result.
  - First capture occurs on the first rising edge after rst_n deasserts, provided in_valid=1 at that edge.
- Boundaries:
  - All-ones + all-ones + cin=1 gives sum=all-ones, cout=1.
  - Zero + zero + cin=1 gives sum=1, cout=0.
  - Full carry propagation (e.g. 1111+0001) must ripple through all cells.

Test Plan:
- a=0000,b=0000,cin=0 -> sum=0000,cout=0; after 1 clk with in_valid=1: sum_q=0000,cout_q=0,ovf_q=0,out_valid=1.
- a=0101,b=0011,cin=0 -> sum=1000,cout=0; registered ovf_q=1 (5+3 overflows signed 4-bit).
- a=0111,b=1000,cin=0 -> sum=1111,cout=0,ovf_q=0. Then a=1111,b=0001,cin=0 -> sum=0000,cout=1,ovf_q=0 (full ripple).
- a=1001,b=0110,cin=1 -> sum=0000,cout=1,ovf_q=0; a=1111,b=1111,cin=1 -> sum=1111,cout=1.
- Stream three in_valid=1 vectors on consecutive cycles, then in_valid=0 -> out_valid high 3 cycles then low; sum_q holds the last result.
- Assert rst_n=0 between clock edges with out_valid=1 -> sum_q/cout_q/ovf_q/out_valid go 0 immediately while combinational sum/cout still track inputs. Exhaustive sweep of 512 (a,b,cin) combinations against a+b+cin also required.
